// File: rtl/sig_hist_pkg.sv
// Shared types and constants for the sampled-value history tracker.
// Holds the fill FSM encoding, the legal parameter ranges and the fill-counter width helper.
package sig_hist_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PRIME = 2'd1,
    FULL  = 2'd2
  } fill_state_t;

  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 16;
  localparam int CNT_W_MIN = 2;
  localparam int CNT_W_MAX = 32;

  // The fill counter must be able to hold the value DEPTH itself.
  function automatic int fill_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sig_history_tracker_sat_counter.sv
// Saturating up-counter with a sticky saturation flag.
// The flag is set on the same edge that the count first becomes all-ones.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_next;

  assign cnt_next = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc && !sat) begin
      cnt <= cnt_next;
      sat <= &cnt_next;
    end
  end

endmodule

// File: rtl/sig_history_tracker.sv
// Registers a_in each enabled edge into a DEPTH-deep history and decodes
// rose/fell/stable, a fill-complete flag and a saturating toggle count.
module sig_history_tracker
  import sig_hist_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             en,
  input  logic             clr,
  output logic [DEPTH-1:0] past_vec,
  output logic             hist_valid,
  output logic             rose,
  output logic             fell,
  output logic             stable,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             cnt_sat
);

  localparam int FW = fill_cnt_w(DEPTH);
  localparam logic [FW-1:0] LAST_PRIME = FW'(DEPTH - 1);
  localparam logic [FW-1:0] TWO        = FW'(2);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_depth_bad
    $error("sig_history_tracker: DEPTH out of range 2..16");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_cnt_w_bad
    $error("sig_history_tracker: CNT_W out of range 2..32");
  end

  fill_state_t   state;
  fill_state_t   next_state;
  logic [FW-1:0] fill_cnt;
  logic          wipe;
  logic          step;
  logic          toggle_inc;
  logic          flags_ok;

  assign wipe = !rst_n || clr;
  assign step = en && !clr;

  always_ff @(posedge clk) begin
    if (wipe) state <= EMPTY;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (step) begin
      case (state)
        EMPTY:   next_state = PRIME;
        PRIME:   if (fill_cnt == LAST_PRIME) next_state = FULL;
        default: next_state = state;
      endcase
    end
  end

  // fill_cnt stops once FULL so it never needs more than DEPTH.
  always_ff @(posedge clk) begin
    if (wipe) begin
      past_vec <= '0;
      fill_cnt <= '0;
    end else if (en) begin
      past_vec <= {past_vec[DEPTH-2:0], a_in};
      if (state != FULL) fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // With no prior sample in EMPTY there is nothing to compare against.
  assign toggle_inc = step && (state != EMPTY) && (a_in != past_vec[0]);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (toggle_inc),
    .cnt   (toggle_cnt),
    .sat   (cnt_sat)
  );

  always_comb begin
    flags_ok   = (state == FULL) || ((state == PRIME) && (fill_cnt >= TWO));
    hist_valid = (state == FULL);
    rose       = flags_ok &&  past_vec[0] && !past_vec[1];
    fell       = flags_ok && !past_vec[0] &&  past_vec[1];
    stable     = flags_ok && (past_vec[0] == past_vec[1]);
  end

endmodule

// File: tb/tb_sig_history_tracker.sv
// Directed, table-driven bench for sig_history_tracker (DEPTH=4) plus a
// hand sequence on a CNT_W=2 instance for counter saturation and clear.
module tb_sig_history_tracker;

  logic       clk = 1'b0;
  logic       rst_n, en, clr, a_in;
  logic [3:0] past_vec;
  logic       hist_valid, rose, fell, stable, cnt_sat;
  logic [7:0] toggle_cnt;

  logic       b_rst_n, b_en, b_clr, b_a;
  logic [3:0] b_past_vec;
  logic       b_hist_valid, b_rose, b_fell, b_stable, b_cnt_sat;
  logic [1:0] b_toggle_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sig_history_tracker #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .en(en), .clr(clr),
    .past_vec(past_vec), .hist_valid(hist_valid), .rose(rose), .fell(fell),
    .stable(stable), .toggle_cnt(toggle_cnt), .cnt_sat(cnt_sat)
  );

  sig_history_tracker #(.DEPTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(b_rst_n), .a_in(b_a), .en(b_en), .clr(b_clr),
    .past_vec(b_past_vec), .hist_valid(b_hist_valid), .rose(b_rose), .fell(b_fell),
    .stable(b_stable), .toggle_cnt(b_toggle_cnt), .cnt_sat(b_cnt_sat)
  );

  typedef struct {
    logic       rst_n, en, clr, a;
    logic [3:0] pv;
    logic       hv, r, f, s;
    logic [7:0] cnt;
    logic       sat;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rn, input logic e, input logic c, input logic a,
                     input logic [3:0] pv, input logic hv, input logic r,
                     input logic f, input logic s, input logic [7:0] cnt);
    vec_t v;
    v.rst_n = rn; v.en = e; v.clr = c; v.a = a;
    v.pv = pv; v.hv = hv; v.r = r; v.f = f; v.s = s; v.cnt = cnt; v.sat = 1'b0;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic step2(input logic rn, input logic c, input logic a);
    b_rst_n = rn; b_en = 1'b1; b_clr = c; b_a = a;
    @(posedge clk); #1;
  endtask

  // Packed B-instance outputs: {past_vec, hv, rose, fell, stable, cnt, sat}
  function automatic logic [31:0] b_obs();
    return {23'd0, b_past_vec, b_hist_valid, b_rose, b_fell, b_stable, b_toggle_cnt, b_cnt_sat};
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; a_in = 1'b0;
    b_rst_n = 1'b0; b_en = 1'b1; b_clr = 1'b0; b_a = 1'b0;

    //   rst en clr a   pv       hv r  f  s  cnt
    add(0, 1, 0, 1, 4'b0000, 0, 0, 0, 0, 8'd0);  // reset with a toggling
    add(0, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 8'd0);
    add(1, 1, 0, 1, 4'b0001, 0, 0, 0, 0, 8'd0);  // first sample, no count
    add(1, 1, 0, 0, 4'b0010, 0, 0, 1, 0, 8'd1);
    add(1, 1, 0, 1, 4'b0101, 0, 1, 0, 0, 8'd2);
    add(1, 1, 0, 0, 4'b1010, 1, 0, 1, 0, 8'd3);  // 4th sample -> FULL
    add(1, 0, 0, 1, 4'b1010, 1, 0, 1, 0, 8'd3);  // en=0 freezes
    add(1, 0, 0, 0, 4'b1010, 1, 0, 1, 0, 8'd3);
    add(1, 0, 0, 1, 4'b1010, 1, 0, 1, 0, 8'd3);
    add(1, 1, 0, 1, 4'b0101, 1, 1, 0, 0, 8'd4);  // resumes
    add(1, 1, 0, 1, 4'b1011, 1, 0, 0, 1, 8'd4);
    add(1, 0, 1, 0, 4'b0000, 0, 0, 0, 0, 8'd0);  // clr overrides en=0
    add(1, 1, 0, 1, 4'b0001, 0, 0, 0, 0, 8'd0);  // constant 1 run
    add(1, 1, 0, 1, 4'b0011, 0, 0, 0, 1, 8'd0);
    add(1, 1, 0, 1, 4'b0111, 0, 0, 0, 1, 8'd0);
    add(1, 1, 0, 1, 4'b1111, 1, 0, 0, 1, 8'd0);
    add(1, 1, 0, 1, 4'b1111, 1, 0, 0, 1, 8'd0);
    add(1, 1, 0, 1, 4'b1111, 1, 0, 0, 1, 8'd0);
    add(1, 1, 1, 1, 4'b0000, 0, 0, 0, 0, 8'd0);  // clr with en=1
    add(1, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 8'd0);
    add(1, 1, 0, 1, 4'b0001, 0, 1, 0, 0, 8'd1);  // PRIME, 2 samples
    add(0, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 8'd0);  // reset mid-fill
    add(1, 1, 0, 1, 4'b0001, 0, 0, 0, 0, 8'd0);  // no count on first sample
    add(1, 1, 0, 1, 4'b0011, 0, 0, 0, 1, 8'd0);
    add(1, 1, 0, 0, 4'b0110, 0, 0, 1, 0, 8'd1);
    add(1, 1, 0, 0, 4'b1100, 1, 0, 0, 1, 8'd1);  // 4 new samples -> FULL

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; en = tbl[i].en; clr = tbl[i].clr; a_in = tbl[i].a;
      @(posedge clk); #1;
      check("vec", i,
            {15'd0, past_vec, hist_valid, rose, fell, stable, toggle_cnt, cnt_sat},
            {15'd0, tbl[i].pv, tbl[i].hv, tbl[i].r, tbl[i].f, tbl[i].s, tbl[i].cnt, tbl[i].sat});
    end

    // CNT_W=2 saturation: {pv, hv, rose, fell, stable, cnt, sat}
    step2(0, 0, 1'b0);
    check("sat_reset", 0, b_obs(), {23'd0, 4'b0000, 4'b0000, 2'd0, 1'b0});
    step2(1, 0, 1'b1);
    check("sat_seq", 1, b_obs(), {23'd0, 4'b0001, 4'b0000, 2'd0, 1'b0});
    step2(1, 0, 1'b0);
    check("sat_seq", 2, b_obs(), {23'd0, 4'b0010, 4'b0010, 2'd1, 1'b0});
    step2(1, 0, 1'b1);
    check("sat_seq", 3, b_obs(), {23'd0, 4'b0101, 4'b0100, 2'd2, 1'b0});
    step2(1, 0, 1'b0);
    check("sat_seq", 4, b_obs(), {23'd0, 4'b1010, 4'b1010, 2'd3, 1'b1});
    step2(1, 0, 1'b1);
    check("sat_seq", 5, b_obs(), {23'd0, 4'b0101, 4'b1100, 2'd3, 1'b1});
    step2(1, 0, 1'b0);
    check("sat_seq", 6, b_obs(), {23'd0, 4'b1010, 4'b1010, 2'd3, 1'b1});
    step2(1, 1, 1'b1);
    check("sat_clr", 7, b_obs(), {23'd0, 4'b0000, 4'b0000, 2'd0, 1'b0});
    step2(1, 0, 1'b1);
    check("sat_after_clr", 8, b_obs(), {23'd0, 4'b0001, 4'b0000, 2'd0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sig_history_tracker.md
# sig_history_tracker

Synthesizable sampled-value history stage for the sampled-value/assertion exercises. It registers a single-bit signal on every rising clock edge and keeps a DEPTH-deep history. From that history it derives rose/fell/stable flags and a saturating toggle count. These are the RTL equivalents of the sampled-value functions, and the downstream checker bench compares them against its concurrent assertions.

## Interface
- DEPTH, 4: number of retained samples; legal range 2..16.
- CNT_W, 8: toggle counter width; legal range 2..32.

- clk  input  1  single clock; all sampling on its rising edge
- rst_n  input  1  reset, synchronous, active-low
- a_in  input  1  observed signal; its pre-edge value is captured at each posedge
- en  input  1  sample enable; 0 freezes all state
- clr  input  1  synchronous clear of history, fill state and counter; priority over en
- past_vec  output  DEPTH  past_vec[0] = newest sample, past_vec[DEPTH-1] = oldest
- hist_valid  output  1  DEPTH samples have been taken since the last reset/clr
- rose  output  1  newest sample 1, previous sample 0
- fell  output  1  newest sample 0, previous sample 1
- stable  output  1  newest sample equals previous sample
- toggle_cnt  output  CNT_W  number of sample-to-sample changes, saturating
- cnt_sat  output  1  sticky; set when toggle_cnt reaches all-ones

## Operation
- Sample step, on a posedge with rst_n=1, clr=0 and en=1:
  - past_vec shifts up by one position.
  - past_vec[0] takes a_in.
  - Fill state advances.
- Fill FSM:
  - EMPTY (0 samples) -> PRIME on the first sample.
  - PRIME (1..DEPTH-1 samples; an internal fill counter tracks the count) -> FULL when the DEPTH-th sample is taken.
  - FULL holds until reset/clr.
- Flag gating:
  - rose, fell and stable are valid only when at least 2 samples are held (PRIME with count>=2, or FULL). Otherwise all three are 0.
  - Exactly one of rose, fell or stable is 1 whenever the flags are valid.
- hist_valid = (state == FULL).
- toggle_cnt:
  - Increments on a sample step when the state is not EMPTY and a_in != past_vec[0].
  - Holds at all-ones once reached.
  - cnt_sat goes to 1 on the same edge the count reaches all-ones and stays 1.
- en=0: history, FSM, counter and flags hold their values; a_in is ignored.
- clr=1 (with rst_n=1) acts exactly like reset regardless of en.
- Outputs are combinational decodes of registered state only; there is no path from a_in to any output.

## Timing
- Reset values (rst_n=0 at a posedge):
  - past_vec = 0, state EMPTY, toggle_cnt = 0, cnt_sat = 0.
  - Therefore hist_valid = rose = fell = stable = 0.
- Latency:
  - A value of a_in present just before posedge k appears on past_vec[0] after posedge k.
  - rose, fell and stable for that sample are visible in the same cycle, after posedge k.
- a_in changing in the same timestep as the posedge: the pre-edge (sampled) value is captured, never the new value.
- First sample after reset: the counter does not increment, because there is no prior sample.
- Second sample: flags become valid.
- hist_valid rises after the DEPTH-th sample edge.
- Reset asserted mid-fill or mid-count: all state returns to reset values at that edge, and filling restarts from EMPTY.
- Saturation: toggles after all-ones leave toggle_cnt unchanged, and cnt_sat stays 1.

## Structure
- Shared package sig_hist_pkg:
  - Fill FSM enum fill_state_t {EMPTY, PRIME, FULL}.
  - DEPTH/CNT_W legal-range constants.
  - A function computing the fill-counter width ($clog2(DEPTH+1)).
- One natural sub-module: sat_counter (CNT_W-bit, inc/clr, saturating, sticky sat flag).
- History shift register and FSM stay in the top.
- Parameter range checks are elaboration-time assertions in the top.

## Test plan
- Reset: hold rst_n=0 for 2 edges with a_in toggling -> past_vec=0, toggle_cnt=0, all flags 0.
- Toggle a_in every clk edge from 1, with DEPTH=4:
  - Edge 1: past_vec[0]=1, flags 0.
  - Edge 2: fell=1, toggle_cnt=1.
  - Edge 3: rose=1, toggle_cnt=2.
  - Edge 4: hist_valid=1, past_vec=4'b1010 or 4'b0101 (matching sample order).
- Constant a_in=1 for 6 edges -> stable=1 from edge 2, toggle_cnt=0, hist_valid from edge 4.
- en=0 for 3 edges mid-stream while a_in toggles -> past_vec, toggle_cnt and flags unchanged. Resumes on the next en=1 edge.
- CNT_W=2, continuous toggling -> toggle_cnt 1, 2, 3, then holds 3. cnt_sat=1 on the edge reaching 3 and stays 1. clr=1 -> toggle_cnt=0, cnt_sat=0, state EMPTY.
- rst_n=0 pulse after 2 samples (state PRIME) -> state EMPTY. The next sample does not increment toggle_cnt, and hist_valid needs 4 new samples.
